// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for 640x480@60 and helpers that derive
// line/frame totals and sync window boundaries from a mode description.
package vga_timing_pkg;

   localparam int VGA640_H_ACTIVE = 640;
   localparam int VGA640_H_FP     = 16;
   localparam int VGA640_H_SYNC   = 96;
   localparam int VGA640_H_BP     = 48;
   localparam int VGA640_V_ACTIVE = 480;
   localparam int VGA640_V_FP     = 10;
   localparam int VGA640_V_SYNC   = 2;
   localparam int VGA640_V_BP     = 33;
   localparam int VGA640_H_TOTAL  = 800;
   localparam int VGA640_V_TOTAL  = 525;

   localparam int MAX_PIPE_DLY = 8;

   function automatic int line_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int sync_start(input int act, input int fp);
      return act + fp;
   endfunction

   function automatic int sync_end(input int act, input int fp, input int sync);
      return act + fp + sync;
   endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Width x depth shift register with clock-enable and synchronous active-low
// clear; collapses to a wire when DEPTH is 0.
module vga_sync_delay #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_ctrl;
         assign unused_ctrl = ^{clk, reset, en};
         assign dout = din;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage [DEPTH];

         always_ff @(posedge clk) begin
            if (!reset) begin
               for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            end else if (en) begin
               stage[0] <= din;
               for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
         end

         assign dout = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v counters, polarity-configurable
// syncs, data enable and line/frame strobes, with a pipeline delay on hs/vs/de.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = VGA640_H_ACTIVE,
   parameter int H_FP     = VGA640_H_FP,
   parameter int H_SYNC   = VGA640_H_SYNC,
   parameter int H_BP     = VGA640_H_BP,
   parameter int V_ACTIVE = VGA640_V_ACTIVE,
   parameter int V_FP     = VGA640_V_FP,
   parameter int V_SYNC   = VGA640_V_SYNC,
   parameter int V_BP     = VGA640_V_BP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int PIPE_DLY = 0,
   parameter int CNT_W    = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_en,
   output logic [CNT_W-1:0] hcnt,
   output logic [CNT_W-1:0] vcnt,
   output logic             active,
   output logic             hs,
   output logic             vs,
   output logic             de,
   output logic             line_start,
   output logic             frame_start
);

   localparam int H_TOTAL  = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL  = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HS_START = sync_start(H_ACTIVE, H_FP);
   localparam int HS_END   = sync_end(H_ACTIVE, H_FP, H_SYNC);
   localparam int VS_START = sync_start(V_ACTIVE, V_FP);
   localparam int VS_END   = sync_end(V_ACTIVE, V_FP, V_SYNC);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   generate
      if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cnt_w
         $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
      end
      if (PIPE_DLY < 0 || PIPE_DLY > MAX_PIPE_DLY) begin : g_bad_pipe_dly
         $error("vga_timing_gen: PIPE_DLY must be 0..8");
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (pix_en) begin
         if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + ONE;
         end else begin
            hcnt <= hcnt + ONE;
         end
      end
   end

   logic       hs0;
   logic       vs0;
   logic [2:0] sync0;
   logic [2:0] sync_d;

   assign active = (int'(hcnt) < H_ACTIVE) && (int'(vcnt) < V_ACTIVE);
   assign hs0    = (int'(hcnt) >= HS_START) && (int'(hcnt) < HS_END);
   assign vs0    = (int'(vcnt) >= VS_START) && (int'(vcnt) < VS_END);

   // Forcing the decode inactive during reset keeps a zero-depth delay line
   // showing idle outputs too, not just the cleared stages.
   assign sync0 = reset ? {hs0, vs0, active} : 3'b000;

   vga_sync_delay #(
      .WIDTH(3),
      .DEPTH(PIPE_DLY)
   ) u_sync_delay (
      .clk  (clk),
      .reset(reset),
      .en   (pix_en),
      .din  (sync0),
      .dout (sync_d)
   );

   assign hs = HS_POL ? sync_d[2] : ~sync_d[2];
   assign vs = VS_POL ? sync_d[1] : ~sync_d[1];
   assign de = sync_d[0];

   assign line_start  = pix_en && (hcnt == '0);
   assign frame_start = pix_en && (hcnt == '0) && (vcnt == '0);

endmodule
